// File: rtl/q_argmax_mask.sv
// q_argmax_mask: streams N_ACTIONS signed Q-values per vector and reports the argmax mask, maximum value and tie flag.
//   clk, rst (sync active-high) | in_valid/in_ready/q_in: one Q-value per accepted beat
//   out_valid/out_ready: result handshake | out_mask (MASK_ACTIVE polarity), out_max, out_tie
module q_argmax_mask #(
  parameter int N_ACTIONS = 4,
  parameter int Q_WIDTH = 16,
  parameter logic MASK_ACTIVE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [Q_WIDTH-1:0] q_in,
  output logic out_valid,
  input  logic out_ready,
  output logic [N_ACTIONS-1:0] out_mask,
  output logic [Q_WIDTH-1:0] out_max,
  output logic out_tie
);
  localparam int CW = $clog2(N_ACTIONS + 1);
  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;
  state_t state, state_n;
  logic [CW-1:0] count;
  logic signed [Q_WIDTH-1:0] max_r;
  logic [N_ACTIONS-1:0] mask_r, bit_i;
  logic accept, last;
  assign in_ready = state != HOLD && !rst;
  assign accept = in_valid && in_ready;
  assign bit_i = N_ACTIONS'(1) << count;
  assign last = count == CW'(N_ACTIONS - 1);
  assign out_valid = state == HOLD;
  assign out_max = max_r;
  assign out_mask = MASK_ACTIVE ? mask_r : ~mask_r;
  // clearing the lowest set bit leaves something only when two or more bits are set
  assign out_tie = |(mask_r & (mask_r - N_ACTIONS'(1)));
  always_comb begin
    state_n = state;
    if (state == HOLD) state_n = out_ready ? IDLE : HOLD;
    else if (accept) state_n = last ? HOLD : SCAN;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      max_r <= '0;
      mask_r <= '0;
    end else if (accept) begin
      count <= count + CW'(1);
      if (state == IDLE || $signed(q_in) > max_r) begin
        max_r <= $signed(q_in);
        mask_r <= bit_i;
      end else if ($signed(q_in) == max_r) mask_r <= mask_r | bit_i;
    end else if (state == HOLD && out_ready) count <= '0;
  end
endmodule

// File: tb/tb_q_argmax_mask.sv
// tb_q_argmax_mask: directed vectors against a queue-based argmax model, checked every cycle, plus literal expectations.
module tb_q_argmax_mask;
  localparam int N = 4;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [15:0] q_in = '0;
  logic in_ready, out_valid, out_tie, in_ready1, out_valid1, out_tie1;
  logic [3:0] out_mask, out_mask1;
  logic [15:0] out_max, out_max1;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  q_argmax_mask #(.N_ACTIONS(N), .Q_WIDTH(16), .MASK_ACTIVE(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .q_in(q_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask), .out_max(out_max), .out_tie(out_tie));
  q_argmax_mask #(.N_ACTIONS(N), .Q_WIDTH(16), .MASK_ACTIVE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .q_in(q_in),
    .out_valid(out_valid1), .out_ready(out_ready), .out_mask(out_mask1), .out_max(out_max1), .out_tie(out_tie1));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  function automatic int fmax(input int q[$]);
    int m = q[0];
    foreach (q[k]) if (q[k] > m) m = q[k];
    return m;
  endfunction
  function automatic logic [3:0] fmask(input int q[$]);
    logic [3:0] r = '0;
    int m = fmax(q);
    foreach (q[k]) if (q[k] == m) r[k] = 1'b1;
    return r;
  endfunction
  int beats[$];
  logic m_hold = 0, m_post_rst = 0, m_tie = 0;
  logic [3:0] m_mask = '0;
  logic [15:0] m_max = '0;
  always @(posedge clk) begin
    m_post_rst <= rst;
    if (rst) begin
      beats.delete();
      m_hold <= 0;
    end else if (m_hold) begin
      if (out_ready) m_hold <= 0;
    end else if (in_valid) begin
      beats.push_back(int'($signed(q_in)));
      if (beats.size() == N) begin
        m_max <= 16'(fmax(beats));
        m_mask <= fmask(beats);
        m_tie <= $countones(fmask(beats)) > 1;
        m_hold <= 1;
        beats.delete();
      end
    end
  end
  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(!m_hold && !rst));
    chk("in_ready1", 32'(in_ready1), 32'(!m_hold && !rst));
    chk("out_valid", 32'(out_valid), 32'(m_hold));
    chk("out_valid1", 32'(out_valid1), 32'(m_hold));
    if (m_hold) begin
      chk("out_mask", 32'(out_mask), 32'(4'(~m_mask)));
      chk("out_mask1", 32'(out_mask1), 32'(m_mask));
      chk("out_max", 32'(out_max), 32'(m_max));
      chk("out_max1", 32'(out_max1), 32'(m_max));
      chk("out_tie", 32'(out_tie), 32'(m_tie));
    end
    if (m_post_rst) begin
      chk("rst_mask", 32'(out_mask), 32'hF);
      chk("rst_mask1", 32'(out_mask1), 32'h0);
      chk("rst_max", 32'(out_max), 32'h0);
      chk("rst_tie", 32'(out_tie), 32'h0);
    end
  end
  task automatic send(input int v, input int gap);
    in_valid = 1;
    q_in = 16'(v);
    @(posedge clk); #1;
    in_valid = 0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask
  task automatic run(input int a, input int b, input int c, input int d, input int gap);
    send(a, gap); send(b, gap); send(c, gap); send(d, 0);
  endtask
  task automatic expect_out(input string name, input logic [3:0] m, input logic [15:0] mx, input logic t);
    int n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk({name, "_latency"}, 32'(n), 32'd0);
    chk({name, "_mask"}, 32'(out_mask), 32'(m));
    chk({name, "_max"}, 32'(out_max), 32'(mx));
    chk({name, "_tie"}, 32'(out_tie), 32'(t));
  endtask
  task automatic take();
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    run(5, -3, 12, 7, 0);
    expect_out("single", 4'b1011, 16'd12, 1'b0);
    take();
    run(9, 9, -1, 9, 0);
    expect_out("tie", 4'b0100, 16'd9, 1'b1);
    chk("tie_mask_active_high", 32'(out_mask1), 32'b1011);
    take();
    run(-8, -2, -5, -2, 0);
    expect_out("signed", 4'b0101, 16'hFFFE, 1'b1);
    take();
    run(5, -3, 12, 7, 0);
    expect_out("bp_pre", 4'b1011, 16'd12, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      q_in = 16'(100 + i);
      @(posedge clk); #1;
    end
    in_valid = 0;
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    expect_out("bp_post", 4'b1011, 16'd12, 1'b0);
    take();
    chk("bp_released_valid", 32'(out_valid), 32'd0);
    chk("bp_released_ready", 32'(in_ready), 32'd1);
    send(100, 0);
    send(50, 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    run(1, 2, 3, 4, 0);
    expect_out("midrst", 4'b0111, 16'd4, 1'b0);
    take();
    run(5, -3, 12, 7, 2);
    expect_out("gaps", 4'b1011, 16'd12, 1'b0);
    take();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/q_argmax_mask.md
Q_ARGMAX_MASK -- requirements
Module: q_argmax_mask

Interface
REQ-001 SHALL have parameter N_ACTIONS, default 4: number of Q-values per vector and width of out_mask.
REQ-002 SHALL have parameter Q_WIDTH, default 16: width of each two's-complement signed Q-value.
REQ-003 SHALL have parameter MASK_ACTIVE, default 1'b0: polarity of a selected bit in out_mask. The default matches the active-low default of the downstream priority encoder.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge triggered.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: q_in holds a valid beat.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-008 SHALL have port q_in, input, Q_WIDTH bits: signed Q-value; beat k of a vector is action k.
REQ-009 SHALL have port out_valid, output, 1 bit: a result is held on the out_* ports.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 SHALL have port out_mask, output, N_ACTIONS bits: bit k is at MASK_ACTIVE iff action k equals the vector maximum.
REQ-012 SHALL have port out_max, output, Q_WIDTH bits: the signed maximum Q-value.
REQ-013 SHALL have port out_tie, output, 1 bit: more than one mask bit is selected.

Function
REQ-014 SHALL implement states IDLE, SCAN and HOLD.
REQ-015 SHALL define a beat as accepted on a cycle where in_valid and in_ready are both 1.
- in_ready = 1 in IDLE and SCAN, 0 in HOLD and while rst = 1.
REQ-016 SHALL, on an accepted beat in IDLE (index 0), load running max = q_in and internal mask = one-hot bit 0, then go to SCAN with beat count 1.
REQ-017 SHALL, on an accepted beat in SCAN at index i (1..N_ACTIONS-1), update using a signed comparison:
- q_in > max: max = q_in, mask = only bit i;
- q_in == max: mask |= bit i;
- q_in < max: no change.
REQ-018 SHALL ignore cycles with in_valid = 0: no state, count or max change; gaps between beats are legal.
REQ-019 SHALL, when beat N_ACTIONS-1 is accepted, enter HOLD and assert out_valid on the next cycle (latency 1 cycle after the last beat).
REQ-020 SHALL, in HOLD, keep out_mask, out_max and out_tie stable until out_valid and out_ready are both 1.
REQ-021 SHALL, on that output handshake, deassert out_valid and return to IDLE on the next cycle with the beat count cleared.
- Minimum period is N_ACTIONS+1 cycles per vector.
REQ-022 SHALL drive out_mask = internal mask when MASK_ACTIVE = 1, and the bitwise inverse of it when MASK_ACTIVE = 0.
REQ-023 SHALL set out_tie = 1 iff the internal mask has two or more bits set.
REQ-024 SHALL never leave the internal mask empty in HOLD: at least one bit is always selected.
REQ-025 SHALL ignore in_valid pulses in HOLD: in_ready = 0, so no beat is accepted.
REQ-026 SHALL keep the beat counter wide enough for N_ACTIONS without wrap; the counter is cleared only by reset or by returning to IDLE.

Reset
REQ-027 SHALL, while rst = 1 at a clock edge, force:
- state = IDLE, count = 0, out_valid = 0, out_tie = 0, out_max = 0;
- out_mask = all bits inactive (all 1 when MASK_ACTIVE = 0, all 0 when MASK_ACTIVE = 1).
REQ-028 SHALL, on reset during SCAN or HOLD, discard the partial or held vector with no output handshake; the next accepted beat is index 0.

Verification
(All scenarios use N_ACTIONS = 4, Q_WIDTH = 16, MASK_ACTIVE = 0 unless stated.)
REQ-029 SHALL cover a single maximum: beats 5, -3, 12, 7 -> out_mask = 4'b1011, out_max = 12, out_tie = 0; out_valid rises one cycle after the fourth beat.
REQ-030 SHALL cover ties: beats 9, 9, -1, 9 -> out_mask = 4'b0100, out_max = 9, out_tie = 1. With MASK_ACTIVE = 1 the same beats -> out_mask = 4'b1011.
REQ-031 SHALL cover signed comparison: beats -8, -2, -5, -2 -> out_mask = 4'b0101, out_max = 16'hFFFE, out_tie = 1.
REQ-032 SHALL cover backpressure: hold out_ready = 0 for 5 cycles after out_valid while pulsing in_valid -> outputs unchanged, in_ready = 0, no beat accepted. Then out_ready = 1 -> out_valid = 0 and in_ready = 1 on the next cycle.
REQ-033 SHALL cover reset mid-scan: accept beats 100, 50, assert rst for 1 cycle, then send 1, 2, 3, 4 -> out_mask = 4'b0111, out_max = 4; nothing from before the reset appears.
REQ-034 SHALL cover input gaps: beats 5, -3, 12, 7 with in_valid low for 2 cycles between each beat -> same result as REQ-029, with out_valid one cycle after the last accepted beat.
